lifo_fifo_buf: RTL and testbench

Parametrised data buffer that succeeds the fixed single-mode stack. It stores up to 2**N words of Wl bits and runs as a LIFO stack or a FIFO queue, selected at run time. It adds full, empty, sticky error and occupancy outputs, and defined behaviour for simultaneous push and pop. It sits between a word producer and a consumer on a single clock domain.

---
 rtl/lifo_fifo_buf_pkg.sv | 17 +
 rtl/lifo_fifo_buf_ram.sv | 29 ++
 rtl/lifo_fifo_buf.sv | 133 +++++++++++++
 tb/tb_lifo_fifo_buf.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lifo_fifo_buf_pkg.sv
// Shared definitions for the run-time selectable LIFO/FIFO buffer.
package lifo_fifo_buf_pkg;

  typedef enum logic {
    MODE_LIFO = 1'b0,
    MODE_FIFO = 1'b1
  } mode_e;

  localparam int unsigned WL_DEFAULT = 6;
  localparam int unsigned N_DEFAULT  = 3;

  // Number of storage entries for an address width of n bits.
  function automatic int unsigned depth(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/lifo_fifo_buf_ram.sv
// DEPTH x Wl register file: one synchronous write port, one asynchronous read port, no reset.
module lifo_fifo_buf_ram
  import lifo_fifo_buf_pkg::*;
#(
  parameter int unsigned Wl = WL_DEFAULT,
  parameter int unsigned N  = N_DEFAULT
) (
  input  logic          clk,
  input  logic          we,
  input  logic [N-1:0]  waddr,
  input  logic [Wl-1:0] wdata,
  input  logic [N-1:0]  raddr,
  output logic [Wl-1:0] rdata
);

  localparam int unsigned DEPTH = depth(N);

  logic [Wl-1:0] mem [DEPTH];

  // Write port: store wdata on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_fifo_buf.sv
// LIFO/FIFO data buffer with full/empty decode, sticky error flag and occupancy count.
module lifo_fifo_buf
  import lifo_fifo_buf_pkg::*;
#(
  parameter int unsigned Wl = WL_DEFAULT,
  parameter int unsigned N  = N_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          mode,
  input  logic          err_clr,
  input  logic [Wl-1:0] dio,
  output logic [Wl-1:0] q,
  output logic          full,
  output logic          empty,
  output logic          error,
  output logic [N:0]    count
);

  localparam int unsigned DEPTH = depth(N);

  mode_e         mode_r, mode_nxt, eff_mode;
  logic [N-1:0]  wr_ptr, wr_ptr_nxt;
  logic [N-1:0]  rd_ptr, rd_ptr_nxt;
  logic [N:0]    count_nxt;
  logic [Wl-1:0] q_nxt;
  logic          error_nxt;
  logic          fault;
  logic          is_empty, is_full;
  logic [N-1:0]  top_addr;
  logic          ram_we;
  logic [N-1:0]  ram_waddr, ram_raddr;
  logic [Wl-1:0] ram_rdata;

  lifo_fifo_buf_ram #(.Wl(Wl), .N(N)) buf_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (dio),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Status flags decoded from the count register only.
  assign empty = (count == '0);
  assign full  = (count == (N+1)'(DEPTH));

  // Next-state logic: the mode input governs any edge where the buffer is empty.
  always_comb begin
    mode_nxt   = mode_r;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    q_nxt      = q;
    fault      = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = wr_ptr;
    ram_raddr  = rd_ptr;

    is_empty = (count == '0);
    is_full  = (count == (N+1)'(DEPTH));
    top_addr = N'(count - (N+1)'(1));
    eff_mode = is_empty ? mode_e'(mode) : mode_r;

    if (is_empty) begin
      mode_nxt = mode_e'(mode);
    end

    // LIFO addresses the top of stack; a combined push/pop replaces the top in place.
    if (eff_mode == MODE_LIFO) begin
      ram_raddr = top_addr;
      ram_waddr = (push && pop) ? top_addr : N'(count);
    end

    if (push && pop) begin
      if (is_empty) begin
        q_nxt = dio;
      end else begin
        q_nxt  = ram_rdata;
        ram_we = 1'b1;
        if (eff_mode == MODE_FIFO) begin
          wr_ptr_nxt = wr_ptr + N'(1);
          rd_ptr_nxt = rd_ptr + N'(1);
        end
      end
    end else if (push) begin
      if (is_full) begin
        fault = 1'b1;
      end else begin
        ram_we    = 1'b1;
        count_nxt = count + (N+1)'(1);
        if (eff_mode == MODE_FIFO) begin
          wr_ptr_nxt = wr_ptr + N'(1);
        end
      end
    end else if (pop) begin
      if (is_empty) begin
        fault = 1'b1;
      end else begin
        q_nxt     = ram_rdata;
        count_nxt = count - (N+1)'(1);
        if (eff_mode == MODE_FIFO) begin
          rd_ptr_nxt = rd_ptr + N'(1);
        end
      end
    end

    // A fault on the same edge as err_clr leaves the flag set.
    error_nxt = fault ? 1'b1 : (err_clr ? 1'b0 : error);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_r <= MODE_LIFO;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      q      <= '0;
      error  <= 1'b0;
    end else begin
      mode_r <= mode_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      q      <= q_nxt;
      error  <= error_nxt;
    end
  end

endmodule

// File: tb/tb_lifo_fifo_buf.sv
// Self-checking bench: queue-based reference model, directed scenarios and random traffic.
module tb_lifo_fifo_buf;

  localparam int unsigned WL    = 6;
  localparam int unsigned NB    = 3;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          push, pop, mode, err_clr;
  logic [WL-1:0] dio;
  logic [WL-1:0] q;
  logic          full, empty, error;
  logic [NB:0]   count;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [WL-1:0] mq[$];
  logic          m_mode;
  logic [WL-1:0] m_q;
  logic          m_err;

  lifo_fifo_buf #(.Wl(WL), .N(NB)) dut (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .mode    (mode),
    .err_clr (err_clr),
    .dio     (dio),
    .q       (q),
    .full    (full),
    .empty   (empty),
    .error   (error),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_mode = 1'b0;
    m_q    = '0;
    m_err  = 1'b0;
  endtask

  // Apply one clock edge of the given inputs to the model.
  task automatic model_edge(input logic pu, input logic po, input logic md,
                            input logic ec, input logic [WL-1:0] d);
    logic flt;
    logic [WL-1:0] tmp;
    flt = 1'b0;
    if (mq.size() == 0) m_mode = md;
    if (pu && po) begin
      if (mq.size() == 0) m_q = d;
      else if (m_mode == 1'b0) begin
        m_q = mq[mq.size()-1];
        tmp = mq.pop_back();
        mq.push_back(d);
      end else begin
        m_q = mq.pop_front();
        mq.push_back(d);
      end
    end else if (pu) begin
      if (mq.size() == DEPTH) flt = 1'b1;
      else mq.push_back(d);
    end else if (po) begin
      if (mq.size() == 0) flt = 1'b1;
      else if (m_mode == 1'b0) m_q = mq.pop_back();
      else m_q = mq.pop_front();
    end
    if (flt) m_err = 1'b1;
    else if (ec) m_err = 1'b0;
  endtask

  task automatic compare_all();
    chk("q",     32'(q),     32'(m_q));
    chk("count", 32'(count), 32'(mq.size()));
    chk("full",  32'(full),  32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("error", 32'(error), 32'(m_err));
  endtask

  // Drive one cycle, advance model at the edge, compare 1 time unit later.
  task automatic step(input logic pu, input logic po, input logic md,
                      input logic ec, input logic [WL-1:0] d);
    push = pu; pop = po; mode = md; err_clr = ec; dio = d;
    @(posedge clk);
    #1;
    model_edge(pu, po, md, ec, d);
    compare_all();
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_q",     32'(q),     32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_error", 32'(error), 32'd0);
    model_reset();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; push = 0; pop = 0; mode = 0; err_clr = 0; dio = '0;
    model_reset();
    #12;
    chk("init_count", 32'(count), 32'd0);
    chk("init_empty", 32'(empty), 32'd1);
    chk("init_error", 32'(error), 32'd0);
    chk("init_q",     32'(q),     32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // LIFO order
    step(1, 0, 0, 0, 6'h07);
    step(1, 0, 0, 0, 6'h05);
    step(1, 0, 0, 0, 6'h17);
    chk("lifo_count3", 32'(count), 32'd3);
    step(0, 1, 0, 0, '0); chk("lifo_pop1", 32'(q), 32'h17);
    step(0, 1, 0, 0, '0); chk("lifo_pop2", 32'(q), 32'h05);
    step(0, 1, 0, 0, '0); chk("lifo_pop3", 32'(q), 32'h07);
    chk("lifo_empty", 32'(empty), 32'd1);
    chk("lifo_err",   32'(error), 32'd0);

    // FIFO order and pointer wrap
    for (int i = 1; i <= 8; i++) step(1, 0, 1, 0, 6'(i));
    chk("fifo_full", 32'(full), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 1, 0, '0); chk("fifo_pop_a", 32'(q), 32'(i));
    end
    for (int i = 9; i <= 11; i++) step(1, 0, 1, 0, 6'(i));
    for (int i = 4; i <= 11; i++) begin
      step(0, 1, 1, 0, '0); chk("fifo_pop_b", 32'(q), 32'(i));
    end

    // Overflow, error clear, underflow
    for (int i = 1; i <= 8; i++) step(1, 0, 1, 0, 6'(i));
    step(1, 0, 1, 0, 6'h3F);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_error", 32'(error), 32'd1);
    step(0, 0, 1, 1, '0);
    chk("clr_error", 32'(error), 32'd0);
    for (int i = 1; i <= 8; i++) step(0, 1, 1, 0, '0);
    chk("drain_q", 32'(q), 32'h08);
    step(0, 1, 1, 0, '0);
    chk("udf_q",     32'(q),     32'h08);
    chk("udf_error", 32'(error), 32'd1);
    step(0, 1, 0, 1, '0);
    chk("udf_beats_clr", 32'(error), 32'd1);
    step(0, 0, 0, 1, '0);

    // Simultaneous push/pop
    step(1, 0, 0, 0, 6'h07);
    step(1, 0, 0, 0, 6'h05);
    step(1, 1, 0, 0, 6'h2A);
    chk("pp_q",     32'(q),     32'h05);
    chk("pp_count", 32'(count), 32'd2);
    step(0, 1, 0, 0, '0); chk("pp_next", 32'(q), 32'h2A);
    step(0, 1, 0, 0, '0);
    step(1, 1, 0, 0, 6'h11);
    chk("pt_q",     32'(q),     32'h11);
    chk("pt_count", 32'(count), 32'd0);
    chk("pt_error", 32'(error), 32'd0);
    step(1, 1, 1, 0, 6'h22);
    chk("pt_fifo_q", 32'(q), 32'h22);

    // Mode lock while non-empty
    step(1, 0, 0, 0, 6'h0C);
    step(1, 0, 1, 0, 6'h0D);
    step(0, 1, 1, 0, '0); chk("lock_pop1", 32'(q), 32'h0D);
    step(0, 1, 1, 0, '0); chk("lock_pop2", 32'(q), 32'h0C);
    step(1, 0, 1, 0, 6'h01);
    step(1, 0, 0, 0, 6'h02);
    step(0, 1, 0, 0, '0); chk("after_lock_fifo", 32'(q), 32'h01);
    step(0, 1, 0, 0, '0);

    // Async reset mid-stream with error set
    step(0, 1, 0, 0, '0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 6'(8'h30 + i));
    chk("pre_rst_count", 32'(count), 32'd5);
    chk("pre_rst_error", 32'(error), 32'd1);
    async_reset();
    step(0, 1, 0, 0, '0);
    chk("post_rst_udf", 32'(error), 32'd1);
    chk("post_rst_q",   32'(q),     32'd0);

    // Random traffic in phases biased towards filling and draining
    for (int ph = 0; ph < 12; ph++) begin
      int bias;
      bias = (ph % 3 == 0) ? 75 : ((ph % 3 == 1) ? 25 : 50);
      for (int c = 0; c < 150; c++) begin
        logic pu, po;
        pu = ($urandom_range(0, 99) < bias);
        po = ($urandom_range(0, 99) < (100 - bias));
        step(pu, po, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
             WL'($urandom_range(0, 63)));
        if ($urandom_range(0, 299) == 0) async_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
